// File: rtl/multdiv_ctrl.sv
// Sequencer between the execute stage and the shared iterative mult/div unit:
// accepts one op, pulses start, stalls while the unit iterates, then hands the result to writeback.
module multdiv_ctrl #(
  parameter int          TIMEOUT = 40,
  parameter logic [4:0]  RSTATUS = 5'd30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic        op_is_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  op_rd,
  output logic        op_ready,
  output logic        stall,
  input  logic        flush,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exception,
  input  logic        wb_ack
);

  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        is_div_q, is_div_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [4:0]  rd_q, rd_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] res_q, res_d;
  logic        exc_q, exc_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      is_div_q <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      exc_q    <= exc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    exc_d    = exc_q;
    case (state_q)
      IDLE: begin
        if (op_valid && !flush) begin
          is_div_d = op_is_div;
          op_a_d   = op_a;
          op_b_d   = op_b;
          rd_d     = op_rd;
          exc_d    = 1'b0;
          state_d  = START;
        end
      end
      // Any RDY seen here belongs to the previous op and is deliberately ignored.
      START: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (md_resultRDY) begin
            res_d   = md_result;
            exc_d   = md_exception;
            state_d = DONE;
          end else if (cnt_q == CNT_LAST) begin
            exc_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (flush || wb_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign op_ready     = (state_q == IDLE);
  assign stall        = (state_q != IDLE);
  assign md_operandA  = op_a_q;
  assign md_operandB  = op_b_q;
  assign ctrl_DIV     = (state_q == START) &&  is_div_q;
  assign ctrl_MULT    = (state_q == START) && !is_div_q;
  assign wb_valid     = (state_q == DONE);
  assign wb_exception = (state_q == DONE) && exc_q;

  // Exceptions report through the status register with a cause code: 5 for divide, 4 for multiply.
  always_comb begin
    wb_rd   = '0;
    wb_data = '0;
    if (state_q == DONE) begin
      if (exc_q) begin
        wb_rd   = RSTATUS;
        wb_data = is_div_q ? 32'd5 : 32'd4;
      end else begin
        wb_rd   = rd_q;
        wb_data = res_q;
      end
    end
  end

endmodule
